// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM states,
// the requester count and the one-hot to binary index encoder.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // 4-to-2 encoder; an all-zero input encodes to 0, so an empty grant
    // always reports index 0.
    function automatic logic [1:0] onehot2bin(input logic [3:0] oh);
        onehot2bin = {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: returns the first asserted
// request found searching start, start+1, ... with wrap-around.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       start,
    output logic [N_REQ-1:0] pick_onehot,
    output logic             pick_valid
);

    logic [7:0] req_dbl;
    logic [3:0] rot;
    logic [3:0] sel;
    logic [7:0] sel_dbl;

    // Rotate so that 'start' sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl     = {req, req} >> start;
        rot         = req_dbl[3:0];
        sel         = rot & 4'(~rot + 4'd1);
        sel_dbl     = {sel, sel} << start;
        pick_onehot = sel_dbl[7:4];
        pick_valid  = |req;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with a bounded hold time.
// The last winner always drops to lowest priority; an owner with
// competitors waiting is preempted after MAX_HOLD cycles (0 = never).
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       grant_id,
    output logic             grant_valid
);

    // Counter width; kept at least 1 bit so the unlimited build still elaborates.
    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [1:0]       gid_q;
    logic             valid_q;
    logic [1:0]       ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;

    logic [N_REQ-1:0] pick_oh;
    logic             pick_valid;

    // While granted, ptr_q is always owner+1, so one picker serves both
    // the idle pick and the release/preempt pick.
    rr_pick4 u_pick (
        .req         (req),
        .start       (ptr_q),
        .pick_onehot (pick_oh),
        .pick_valid  (pick_valid)
    );

    // Next-state logic: enable, release, preempt, then hold, in that priority.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (en && pick_valid) begin
                    grant_d = pick_oh;
                    state_d = GRANT;
                    ptr_d   = onehot2bin(pick_oh) + 2'd1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!en) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (!(|(req & grant_q))) begin
                    ptr_d = gid_q + 2'd1;
                    if (pick_valid) begin
                        grant_d = pick_oh;
                        ptr_d   = onehot2bin(pick_oh) + 2'd1;
                        hold_d  = '0;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) &&
                             (|(req & ~grant_q))) begin
                    grant_d = pick_oh;
                    ptr_d   = onehot2bin(pick_oh) + 2'd1;
                    hold_d  = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = HW'(hold_q + 1'b1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; index and valid derived from the same next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= 2'd0;
            valid_q <= 1'b0;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= onehot2bin(grant_d);
            valid_q <= (state_d == GRANT);
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = gid_q;
    assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two builds (MAX_HOLD = 8 and MAX_HOLD = 0) share
// the stimulus; a behavioural model predicts each edge's outputs into a
// queue and a monitor compares them on the falling edge.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;

    logic [3:0] g8, g0;
    logic [1:0] id8, id0;
    logic       v8, v0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [6:0] q8[$];
    logic [6:0] q0[$];

    int owner[2];
    int last[2];
    int held[2];
    int mh[2];

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8)) u_h8 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .grant(g8), .grant_id(id8), .grant_valid(v8)
    );

    rr_arbiter4 #(.MAX_HOLD(0)) u_h0 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .grant(g0), .grant_id(id0), .grant_valid(v0)
    );

    // First requester at or after position s, wrapping; -1 when none.
    function automatic int first_from(input logic [3:0] r, input int s);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (s + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [6:0] expected(input int o);
        logic [3:0] g;
        logic [1:0] id;
        g  = 4'd0;
        id = 2'd0;
        if (o >= 0) begin
            g[o] = 1'b1;
            id   = 2'(o);
        end
        return {(o >= 0), id, g};
    endfunction

    // Reference model: who owns the resource, who won last, how long held.
    initial begin
        mh[0] = 8;
        mh[1] = 0;
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1; last[d] = 3; held[d] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    owner[d] = -1; last[d] = 3; held[d] = 0;
                end else if (!en) begin
                    owner[d] = -1;
                end else if (owner[d] < 0) begin
                    owner[d] = first_from(req, last[d] + 1);
                    if (owner[d] >= 0) begin
                        last[d] = owner[d]; held[d] = 1;
                    end
                end else if (!req[owner[d]]) begin
                    owner[d] = first_from(req, owner[d] + 1);
                    if (owner[d] >= 0) begin
                        last[d] = owner[d]; held[d] = 1;
                    end
                end else if (mh[d] != 0 && held[d] >= mh[d] &&
                             (req & ~(4'd1 << owner[d])) != 4'd0) begin
                    owner[d] = first_from(req & ~(4'd1 << owner[d]), owner[d] + 1);
                    last[d]  = owner[d];
                    held[d]  = 1;
                end else begin
                    held[d] = held[d] + 1;
                end
                if (d == 0) q8.push_back(expected(owner[d]));
                else        q0.push_back(expected(owner[d]));
            end
        end
    end

    task automatic compare(input string nm, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got valid=%b id=%0d grant=%b, expected valid=%b id=%0d grant=%b",
                     nm, cyc, got[6], got[5:4], got[3:0], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    // Monitor: outputs are presented every cycle; pop and compare away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q8.size() > 0) compare("hold8", {v8, id8, g8}, q8.pop_front());
            if (q0.size() > 0) compare("hold0", {v0, id0, g0}, q0.pop_front());
        end
    end

    task automatic drive(input logic r, input logic e, input logic [3:0] q, input int n);
        for (int i = 0; i < n; i++) begin
            rst = r; en = e; req = q;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] rq;
        logic       re, rr;
        rst = 1'b1; en = 1'b0; req = 4'd0;
        // single requester after reset
        drive(1'b1, 1'b0, 4'b0000, 2);
        drive(1'b0, 1'b1, 4'b0100, 6);
        // full contention rotation
        drive(1'b1, 1'b0, 4'b0000, 1);
        drive(1'b0, 1'b1, 4'b1111, 42);
        // back-to-back release from owner 1
        drive(1'b1, 1'b0, 4'b0000, 1);
        drive(1'b0, 1'b1, 4'b0010, 2);
        drive(1'b0, 1'b1, 4'b1011, 2);
        drive(1'b0, 1'b1, 4'b1001, 3);
        // lone requester never preempted
        drive(1'b0, 1'b1, 4'b0010, 20);
        drive(1'b0, 1'b1, 4'b0110, 3);
        // enable drop mid-grant, ptr preserved, then reset mid-grant
        drive(1'b1, 1'b0, 4'b0000, 1);
        drive(1'b0, 1'b1, 4'b0100, 3);
        drive(1'b0, 1'b0, 4'b1111, 4);
        drive(1'b0, 1'b1, 4'b1111, 3);
        drive(1'b1, 1'b1, 4'b1111, 1);
        drive(1'b0, 1'b1, 4'b1111, 3);
        // long hold by owner 0 against requester 1
        drive(1'b1, 1'b0, 4'b0000, 1);
        drive(1'b0, 1'b1, 4'b0011, 50);
        drive(1'b0, 1'b1, 4'b0010, 3);
        drive(1'b0, 1'b1, 4'b1011, 2);
        // randomized traffic with sticky request patterns
        rq = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 15) rq = 4'($urandom_range(0, 15));
            re = ($urandom_range(0, 29) != 0);
            rr = ($urandom_range(0, 199) == 0);
            drive(rr, re, rq, 1);
        end
        drive(1'b0, 1'b1, 4'b0000, 2);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
